// File: rtl/adder_tree_arbiter_pkg.sv
// Shared definitions for the adder-tree arbiter: FSM encoding and datapath widths.
package adder_tree_arbiter_pkg;
  localparam int LANE_W  = 16;
  localparam int VEC_W   = 128;
  localparam int REQ_N   = 4;
  localparam int TIMER_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;
endpackage

// File: rtl/adder_tree_arbiter_if.sv
// Requester, engine and response signals of the arbiter, bundled with directional views.
interface adder_tree_arbiter_if;
  import adder_tree_arbiter_pkg::*;

  logic [REQ_N-1:0]       req_valid;
  logic [REQ_N-1:0]       req_ready;
  logic [REQ_N*VEC_W-1:0] req_din;
  logic                   eng_start;
  logic [VEC_W-1:0]       eng_din;
  logic                   eng_done;
  logic [LANE_W-1:0]      eng_dout;
  logic                   resp_valid;
  logic [1:0]             resp_id;
  logic [LANE_W-1:0]      resp_data;
  logic                   resp_err;

  modport slave (
    input  req_valid, req_din, eng_done, eng_dout,
    output req_ready, eng_start, eng_din, resp_valid, resp_id, resp_data, resp_err
  );

  modport master (
    output req_valid, req_din, eng_done, eng_dout,
    input  req_ready, eng_start, eng_din, resp_valid, resp_id, resp_data, resp_err
  );
endinterface

// File: rtl/adder_tree_arbiter_rr_pick4.sv
// Cyclic priority pick: first set pending bit at or after ptr, wrapping modulo 4.
module rr_pick4 (
  input  logic [3:0] pending,
  input  logic [1:0] ptr,
  output logic       found,
  output logic [1:0] idx
);
  // Scan from the farthest offset down so the nearest hit is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (pending[2'(ptr + 2'(k))]) begin
        found = 1'b1;
        idx   = 2'(ptr + 2'(k));
      end
    end
  end
endmodule

// File: rtl/adder_tree_arbiter.sv
// Round-robin arbiter sharing one adder-tree engine among four requesters, with timeout abort.
module adder_tree_arbiter
  import adder_tree_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int NREQ    = 4
) (
  input  logic                clk,
  input  logic                rst,
  adder_tree_arbiter_if.slave bus,
  output logic                busy
);
  state_t             state, state_nxt;
  logic [NREQ-1:0]    pending, accept, clr;
  logic [VEC_W-1:0]   hold [NREQ];
  logic [1:0]         rr_ptr, sel;
  logic [TIMER_W-1:0] timer;
  logic               pick_found;
  logic [1:0]         pick_idx;
  logic               expired;

  assign accept        = bus.req_valid & ~pending;
  assign bus.req_ready = ~pending;
  assign busy          = (state != IDLE);
  assign expired       = (timer == TIMER_W'(TIMEOUT - 1));

  rr_pick4 u_pick (
    .pending (pending),
    .ptr     (rr_ptr),
    .found   (pick_found),
    .idx     (pick_idx)
  );

  // Capture stage: operands are frozen while a request is pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      for (int i = 0; i < NREQ; i++) hold[i] <= '0;
    end else begin
      pending <= (pending & ~clr) | accept;
      for (int i = 0; i < NREQ; i++) begin
        if (accept[i]) hold[i] <= bus.req_din[VEC_W*i +: VEC_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus.eng_start  = 1'b0;
    bus.eng_din    = '0;
    bus.resp_valid = 1'b0;
    bus.resp_id    = 2'd0;
    clr            = '0;
    case (state)
      IDLE:  if (pick_found) state_nxt = ISSUE;
      ISSUE: begin
        bus.eng_start = 1'b1;
        bus.eng_din   = hold[sel];
        state_nxt     = WAIT;
      end
      WAIT: begin
        bus.eng_din = hold[sel];
        if (bus.eng_done || expired) state_nxt = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_id    = sel;
        clr[sel]       = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Engine stage: a done pulse coinciding with expiry takes the normal path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel           <= 2'd0;
      rr_ptr        <= 2'd0;
      timer         <= '0;
      bus.resp_data <= '0;
      bus.resp_err  <= 1'b0;
    end else begin
      case (state)
        IDLE:  if (pick_found) sel <= pick_idx;
        ISSUE: timer <= '0;
        WAIT: begin
          if (bus.eng_done) begin
            bus.resp_data <= bus.eng_dout;
            bus.resp_err  <= 1'b0;
          end else if (expired) begin
            bus.resp_data <= '0;
            bus.resp_err  <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESP:    rr_ptr <= sel + 2'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_tree_arbiter.sv
// Scoreboard bench for adder_tree_arbiter with a delayed-done engine model.
module tb_adder_tree_arbiter;
  import adder_tree_arbiter_pkg::*;

  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  adder_tree_arbiter_if bus ();

  adder_tree_arbiter #(.TIMEOUT(TO), .NREQ(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] data;
    logic        err;
    int          delta;
  } exp_t;

  exp_t         expq[$];
  logic [127:0] vec [4];
  int           vectors    = 0;
  int           miscompares = 0;
  int           cyc        = 0;
  int           last_start = 0;
  int           eng_delay  = 4;
  bit           suppress   = 1'b0;
  int           mptr       = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] lane_sum(input logic [127:0] v);
    logic [15:0] s = 16'd0;
    for (int l = 0; l < 8; l++) s = s + v[16*l +: 16];
    return s;
  endfunction

  // Reference: requesters pending together are served cyclically from the pointer.
  task automatic push_burst(input logic [3:0] mask);
    int   p0 = mptr;
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      int id = (p0 + k) % 4;
      if (mask[id]) begin
        e.id = 2'(id);
        if (suppress || eng_delay > TO) begin
          e.data = 16'd0; e.err = 1'b1; e.delta = TO + 1;
        end else begin
          e.data = lane_sum(vec[id]); e.err = 1'b0; e.delta = eng_delay + 1;
        end
        expq.push_back(e);
        mptr = (id + 1) % 4;
      end
    end
  endtask

  task automatic send(input logic [3:0] mask);
    bus.req_din   = {vec[3], vec[2], vec[1], vec[0]};
    bus.req_valid = mask;
    @(negedge clk);
    bus.req_valid = 4'd0;
  endtask

  task automatic wait_start();
    int n = 0;
    while (bus.eng_start !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      vectors++; miscompares++;
      $display("FAIL wait_start: eng_start not seen within 50 cycles");
    end
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (expq.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL drain: %0d responses missing after 400 cycles", expq.size());
      expq.delete();
    end
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    mptr = 0;
    @(negedge clk);
  endtask

  initial begin : engine
    int           cnt = 0;
    logic [127:0] cap = '0;
    bus.eng_done = 1'b0;
    bus.eng_dout = 16'd0;
    forever begin
      @(negedge clk);
      bus.eng_done = 1'b0;
      bus.eng_dout = 16'($urandom);
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0 && !suppress) begin
          bus.eng_done = 1'b1;
          bus.eng_dout = lane_sum(cap);
        end
      end
      if (bus.eng_start === 1'b1) begin
        cnt = eng_delay;
        cap = bus.eng_din;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.eng_start === 1'b1) last_start = cyc;
      if (bus.resp_valid === 1'b1) begin
        if (expq.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_resp: id %0d data %0h err %0b, expected no response",
                   bus.resp_id, bus.resp_data, bus.resp_err);
        end else begin
          e = expq.pop_front();
          check("resp_id",    128'(bus.resp_id),   128'(e.id));
          check("resp_data",  128'(bus.resp_data), 128'(e.data));
          check("resp_err",   128'(bus.resp_err),  128'(e.err));
          check("resp_delay", 128'(cyc - last_start), 128'(e.delta));
        end
      end
    end
  end

  initial begin : stimulus
    logic [127:0] a_val;
    logic [3:0]   m;
    rst           = 1'b1;
    bus.req_valid = 4'd0;
    bus.req_din   = '0;
    for (int i = 0; i < 4; i++) vec[i] = '0;
    repeat (2) @(negedge clk);

    check("rst_req_ready",  128'(bus.req_ready),  128'(4'hF));
    check("rst_eng_start",  128'(bus.eng_start),  128'(0));
    check("rst_eng_din",    bus.eng_din,          128'(0));
    check("rst_resp_valid", 128'(bus.resp_valid), 128'(0));
    check("rst_resp_id",    128'(bus.resp_id),    128'(0));
    check("rst_resp_data",  128'(bus.resp_data),  128'(0));
    check("rst_resp_err",   128'(bus.resp_err),   128'(0));
    check("rst_busy",       128'(busy),           128'(0));
    rst = 1'b0;
    @(negedge clk);

    // Single request, all lanes 1, with latency checks
    vec[0] = {8{16'h0001}};
    push_burst(4'b0001);
    send(4'b0001);
    check("ready_after_accept", 128'(bus.req_ready), 128'(4'hE));
    check("busy_idle_cycle",    128'(busy),          128'(0));
    @(negedge clk);
    check("start_latency",   128'(bus.eng_start), 128'(1));
    check("eng_din_issue",   bus.eng_din,         vec[0]);
    check("busy_issue",      128'(busy),          128'(1));
    drain();

    // All four at once from pointer 0, then 1 and 0 together
    pulse_reset();
    for (int i = 0; i < 4; i++) vec[i] = {8{16'(i + 1)}};
    push_burst(4'b1111);
    send(4'b1111);
    drain();
    push_burst(4'b0011);
    send(4'b0011);
    drain();

    // Overflow wraps modulo 2^16
    vec[2] = {8{16'hFFFF}};
    push_burst(4'b0100);
    send(4'b0100);
    drain();

    // Silent engine times out, then normal service resumes
    suppress = 1'b1;
    vec[3] = {8{16'h0123}};
    push_burst(4'b1000);
    send(4'b1000);
    drain();
    suppress = 1'b0;
    push_burst(4'b1000);
    send(4'b1000);
    drain();

    // Done on the expiry cycle wins; done one cycle later is ignored
    eng_delay = TO;
    vec[1] = {8{16'h0F0F}};
    push_burst(4'b0010);
    send(4'b0010);
    drain();
    eng_delay = TO + 1;
    push_burst(4'b0010);
    send(4'b0010);
    drain();
    eng_delay = 4;

    // Accept during WAIT; re-request from the busy requester is ignored
    vec[0] = {8{16'h0011}};
    a_val  = vec[0];
    push_burst(4'b0001);
    send(4'b0001);
    wait_start();
    @(negedge clk);
    vec[0] = {8{16'h7777}};
    vec[2] = {8{16'h0202}};
    push_burst(4'b0100);
    send(4'b0101);
    check("eng_din_stable", bus.eng_din, a_val);
    check("ready_during_wait", 128'(bus.req_ready), 128'(4'hA));
    drain();

    // Randomized bursts
    for (int t = 0; t < 25; t++) begin
      m = 4'($urandom_range(1, 15));
      eng_delay = int'($urandom_range(1, 8));
      for (int i = 0; i < 4; i++)
        vec[i] = {$urandom, $urandom, $urandom, $urandom};
      push_burst(m);
      send(m);
      drain();
    end
    eng_delay = 4;

    // Reset mid-WAIT drops the operation; late done is ignored
    vec[1] = {8{16'h0055}};
    send(4'b0010);
    wait_start();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_wait_ready", 128'(bus.req_ready), 128'(4'hF));
    check("rst_wait_busy",  128'(busy),          128'(0));
    @(negedge clk);
    rst  = 1'b0;
    mptr = 0;
    repeat (10) @(negedge clk);
    check("post_rst_ready", 128'(bus.req_ready),  128'(4'hF));
    check("post_rst_busy",  128'(busy),           128'(0));
    vec[2] = {8{16'h1000}};
    push_burst(4'b0100);
    send(4'b0100);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
